// File: rtl/snake_grid_renderer_if.sv
// Bus bundle between the snake game logic / VGA timing side (master) and the
// grid renderer (slave): frame trigger, packed snake body, food, game state,
// per-pixel colour query and its result.
interface snake_grid_renderer_if #(
  parameter int MAX_LEN = 64
);
  logic                   frame_start;
  logic [5*MAX_LEN-1:0]   snake_x_1dim;
  logic [5*MAX_LEN-1:0]   snake_y_1dim;
  logic [5:0]             snake_length;
  logic [4:0]             food_x;
  logic [4:0]             food_y;
  logic [1:0]             game_state;
  logic [9:0]             pix_x;
  logic [9:0]             pix_y;
  logic                   pix_valid;
  logic [11:0]            rgb;
  logic                   rgb_valid;
  logic                   busy;
  logic                   seg_dropped;

  modport master (
    output frame_start, snake_x_1dim, snake_y_1dim, snake_length,
    output food_x, food_y, game_state, pix_x, pix_y, pix_valid,
    input  rgb, rgb_valid, busy, seg_dropped
  );

  modport slave (
    input  frame_start, snake_x_1dim, snake_y_1dim, snake_length,
    input  food_x, food_y, game_state, pix_x, pix_y, pix_valid,
    output rgb, rgb_valid, busy, seg_dropped
  );
endinterface

// File: rtl/snake_grid_renderer.sv
// Snake grid renderer: once per frame rasterises the snake body and food into
// a cell-occupancy bitmap (work copy), then commits it to a display copy that
// serves per-pixel colour queries through a fixed two-stage pipeline.
module snake_grid_renderer #(
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 24,
  parameter int MAX_LEN = 64,
  parameter int CELL_PX = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  snake_grid_renderer_if.slave  bus
);

  localparam int NCELL = GRID_W * GRID_H;
  localparam int BUS_W = 5 * MAX_LEN;
  localparam int OFF_W = $clog2(BUS_W);
  localparam int IDX_W = $clog2(NCELL);

  localparam logic [9:0] CELL_DIV = 10'(CELL_PX);
  localparam logic [9:0] AREA_W   = 10'(GRID_W * CELL_PX);
  localparam logic [9:0] AREA_H   = 10'(GRID_H * CELL_PX);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLEAR  = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  localparam logic [1:0] GS_DIE = 2'b01;

  // Colour priority: outside area, head, body, food, background.
  function automatic logic [11:0] colour_sel(
    input logic in_area,
    input logic is_head,
    input logic is_body,
    input logic is_food,
    input logic is_die
  );
    logic [11:0] c;
    if (!in_area)      c = 12'h000;
    else if (is_head)  c = is_die ? 12'hFFF : 12'h0F0;
    else if (is_body)  c = is_die ? 12'h888 : 12'h080;
    else if (is_food)  c = 12'hF00;
    else               c = 12'h111;
    return c;
  endfunction

  // Scan FSM and work copy
  logic [1:0]        state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic [5:0]        len_q, len_d;
  logic [BUS_W-1:0]  snap_x_q, snap_x_d;
  logic [BUS_W-1:0]  snap_y_q, snap_y_d;
  logic [4:0]        snap_food_x_q, snap_food_x_d;
  logic [4:0]        snap_food_y_q, snap_food_y_d;
  logic [1:0]        snap_gs_q, snap_gs_d;
  logic [NCELL-1:0]  work_bmp_q, work_bmp_d;
  logic [4:0]        head_x_q, head_x_d;
  logic [4:0]        head_y_q, head_y_d;
  logic              head_valid_q, head_valid_d;
  logic              drop_q, drop_d;

  // Display copy read by the query pipeline
  logic [NCELL-1:0]  disp_bmp_q, disp_bmp_d;
  logic [4:0]        disp_head_x_q, disp_head_x_d;
  logic [4:0]        disp_head_y_q, disp_head_y_d;
  logic              disp_head_valid_q, disp_head_valid_d;
  logic [4:0]        disp_food_x_q, disp_food_x_d;
  logic [4:0]        disp_food_y_q, disp_food_y_d;
  logic              disp_food_valid_q, disp_food_valid_d;
  logic [1:0]        disp_gs_q, disp_gs_d;

  // Query pipeline
  logic [4:0]        cx_p1_q, cx_p1_d;
  logic [4:0]        cy_p1_q, cy_p1_d;
  logic              in_area_p1_q, in_area_p1_d;
  logic              vld_p1_q, vld_p1_d;
  logic [11:0]       rgb_p2_q, rgb_p2_d;
  logic              vld_p2_q, vld_p2_d;

  // Current segment being scanned
  logic [OFF_W-1:0]  seg_off;
  logic [4:0]        seg_x;
  logic [4:0]        seg_y;
  logic              seg_in;
  logic [IDX_W-1:0]  seg_bit;

  assign seg_off = OFF_W'(idx_q) * OFF_W'(5);
  assign seg_x   = snap_x_q[seg_off +: 5];
  assign seg_y   = snap_y_q[seg_off +: 5];
  assign seg_in  = (int'(seg_x) < GRID_W) && (int'(seg_y) < GRID_H);
  assign seg_bit = seg_in ? IDX_W'(int'(seg_y) * GRID_W + int'(seg_x)) : '0;

  // Frame FSM: snapshot inputs, rasterise one segment per cycle, commit.
  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    len_d             = len_q;
    snap_x_d          = snap_x_q;
    snap_y_d          = snap_y_q;
    snap_food_x_d     = snap_food_x_q;
    snap_food_y_d     = snap_food_y_q;
    snap_gs_d         = snap_gs_q;
    work_bmp_d        = work_bmp_q;
    head_x_d          = head_x_q;
    head_y_d          = head_y_q;
    head_valid_d      = head_valid_q;
    drop_d            = drop_q;
    disp_bmp_d        = disp_bmp_q;
    disp_head_x_d     = disp_head_x_q;
    disp_head_y_d     = disp_head_y_q;
    disp_head_valid_d = disp_head_valid_q;
    disp_food_x_d     = disp_food_x_q;
    disp_food_y_d     = disp_food_y_q;
    disp_food_valid_d = disp_food_valid_q;
    disp_gs_d         = disp_gs_q;

    // A new frame pulse always wins, aborting any frame in flight.
    if (bus.frame_start) begin
      state_d = ST_CLEAR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_CLEAR: begin
          work_bmp_d    = '0;
          snap_x_d      = bus.snake_x_1dim;
          snap_y_d      = bus.snake_y_1dim;
          len_d         = bus.snake_length;
          snap_food_x_d = bus.food_x;
          snap_food_y_d = bus.food_y;
          snap_gs_d     = bus.game_state;
          drop_d        = 1'b0;
          idx_d         = '0;
          head_x_d      = '0;
          head_y_d      = '0;
          head_valid_d  = 1'b0;
          state_d       = (bus.snake_length == 6'd0) ? ST_COMMIT : ST_SCAN;
        end
        ST_SCAN: begin
          if (seg_in) work_bmp_d[seg_bit] = 1'b1;
          else        drop_d = 1'b1;
          if (idx_q == 6'd0) begin
            head_x_d     = seg_x;
            head_y_d     = seg_y;
            head_valid_d = seg_in;
          end
          if (idx_q == len_q - 6'd1) state_d = ST_COMMIT;
          else                       idx_d   = idx_q + 6'd1;
        end
        ST_COMMIT: begin
          disp_bmp_d        = work_bmp_q;
          disp_head_x_d     = head_x_q;
          disp_head_y_d     = head_y_q;
          disp_head_valid_d = head_valid_q;
          disp_food_x_d     = snap_food_x_q;
          disp_food_y_d     = snap_food_y_q;
          disp_food_valid_d = int'(snap_food_y_q) < GRID_H;
          disp_gs_d         = snap_gs_q;
          state_d           = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM, snapshot and work-bitmap registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      len_q         <= '0;
      snap_x_q      <= '0;
      snap_y_q      <= '0;
      snap_food_x_q <= '0;
      snap_food_y_q <= '0;
      snap_gs_q     <= '0;
      work_bmp_q    <= '0;
      head_x_q      <= '0;
      head_y_q      <= '0;
      head_valid_q  <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      snap_x_q      <= snap_x_d;
      snap_y_q      <= snap_y_d;
      snap_food_x_q <= snap_food_x_d;
      snap_food_y_q <= snap_food_y_d;
      snap_gs_q     <= snap_gs_d;
      work_bmp_q    <= work_bmp_d;
      head_x_q      <= head_x_d;
      head_y_q      <= head_y_d;
      head_valid_q  <= head_valid_d;
      drop_q        <= drop_d;
    end
  end

  // Display registers, only changed by COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_bmp_q        <= '0;
      disp_head_x_q     <= '0;
      disp_head_y_q     <= '0;
      disp_head_valid_q <= 1'b0;
      disp_food_x_q     <= '0;
      disp_food_y_q     <= '0;
      disp_food_valid_q <= 1'b0;
      disp_gs_q         <= '0;
    end else begin
      disp_bmp_q        <= disp_bmp_d;
      disp_head_x_q     <= disp_head_x_d;
      disp_head_y_q     <= disp_head_y_d;
      disp_head_valid_q <= disp_head_valid_d;
      disp_food_x_q     <= disp_food_x_d;
      disp_food_y_q     <= disp_food_y_d;
      disp_food_valid_q <= disp_food_valid_d;
      disp_gs_q         <= disp_gs_d;
    end
  end

  // Query lookups for stage 2
  logic              q_cell_ok;
  logic [IDX_W-1:0]  q_bit;
  logic              q_head;
  logic              q_body;
  logic              q_food;

  assign q_cell_ok = in_area_p1_q && (int'(cy_p1_q) < GRID_H) && (int'(cx_p1_q) < GRID_W);
  assign q_bit     = q_cell_ok ? IDX_W'(int'(cy_p1_q) * GRID_W + int'(cx_p1_q)) : '0;
  assign q_body    = q_cell_ok && disp_bmp_q[q_bit];
  assign q_head    = disp_head_valid_q && (cx_p1_q == disp_head_x_q) && (cy_p1_q == disp_head_y_q);
  assign q_food    = disp_food_valid_q && (cx_p1_q == disp_food_x_q) && (cy_p1_q == disp_food_y_q);

  // Query pipeline next-state: cell coordinates, then colour.
  always_comb begin
    // stage p1: pixel -> cell
    cx_p1_d      = 5'(bus.pix_x / CELL_DIV);
    cy_p1_d      = 5'(bus.pix_y / CELL_DIV);
    in_area_p1_d = (bus.pix_x < AREA_W) && (bus.pix_y < AREA_H);
    vld_p1_d     = bus.pix_valid;
    // stage p2: cell -> colour
    rgb_p2_d     = colour_sel(in_area_p1_q, q_head, q_body, q_food, disp_gs_q == GS_DIE);
    vld_p2_d     = vld_p1_q;
  end

  // Query pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_p1_q      <= '0;
      cy_p1_q      <= '0;
      in_area_p1_q <= 1'b0;
      vld_p1_q     <= 1'b0;
      rgb_p2_q     <= '0;
      vld_p2_q     <= 1'b0;
    end else begin
      cx_p1_q      <= cx_p1_d;
      cy_p1_q      <= cy_p1_d;
      in_area_p1_q <= in_area_p1_d;
      vld_p1_q     <= vld_p1_d;
      rgb_p2_q     <= rgb_p2_d;
      vld_p2_q     <= vld_p2_d;
    end
  end

  assign bus.rgb         = rgb_p2_q;
  assign bus.rgb_valid   = vld_p2_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.seg_dropped = drop_q;

endmodule
